te_commit_fifo: RTL and testbench

//   Elastic buffer between the CVA6 commit ports and the trace-encoder ingress FSM.

---
 rtl/te_commit_fifo.sv | 111 +++++++++++
 tb/tb_te_commit_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/te_commit_fifo.sv
// Commit-to-trace elastic buffer: compacts 0..NRET retired entries per cycle into a
// first-word-fall-through FIFO. Entries that do not fit are dropped and counted.
module te_commit_fifo #(
  parameter int NRET    = 2,
  parameter int ENTRY_W = 64,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NRET-1:0]           valid_i,
  input  logic [NRET*ENTRY_W-1:0]   entry_i,
  input  logic                      flush_i,
  output logic                      valid_o,
  output logic [ENTRY_W-1:0]        entry_o,
  input  logic                      ready_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      overflow_o,
  output logic [CNT_W-1:0]          drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  // One extra bit so space and lane tallies never wrap while comparing.
  localparam int SW    = CW + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [SW-1:0]    slot_t;

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  ptr_t            wr_ptr_q, wr_ptr_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic            pop;
  slot_t           space, n_valid, pushed, drops;
  logic [NRET-1:0] lane_we;
  ptr_t            lane_addr [NRET];
  logic [CNT_W:0]  drop_sum;

  // NOTE: every signal gets a default before the loop so no path leaves a value
  // unassigned (no latch); the running tallies rely on blocking '=' ordering.
  always_comb begin
    pop     = (count_q != '0) & ready_i;
    space   = slot_t'(DEPTH) - slot_t'(count_q) + slot_t'(pop);
    n_valid = '0;
    pushed  = '0;
    lane_we = '0;
    for (int k = 0; k < NRET; k++) begin
      lane_addr[k] = wr_ptr_q + ptr_t'(pushed);
      if (valid_i[k]) begin
        n_valid = n_valid + slot_t'(1);
        if (!flush_i && (pushed < space)) begin
          lane_we[k] = 1'b1;
          pushed     = pushed + slot_t'(1);
        end
      end
    end

    // Pushes squashed by a flush are discarded, not reported as drops.
    drops      = flush_i ? '0 : (n_valid - pushed);
    overflow_d = (drops != '0);
    drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(drops);
    drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + ptr_t'(pushed);
      rd_ptr_d = rd_ptr_q + ptr_t'(pop);
      count_d  = CW'(slot_t'(count_q) + pushed - slot_t'(pop));
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates visibility, so stale
  // contents are never observed and the array can map onto plain RAM/flops.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NRET; k++) begin
      if (lane_we[k]) mem_q[lane_addr[k]] <= entry_i[k*ENTRY_W +: ENTRY_W];
    end
  end

  assign valid_o    = (count_q != '0);
  assign entry_o    = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_te_commit_fifo.sv
// Scoreboard bench for te_commit_fifo (NRET=2, ENTRY_W=64, DEPTH=16, CNT_W=16):
// accepted entries are queued as driven and compared as the DUT hands them out.
module tb_te_commit_fifo;

  localparam int DEPTH = 16;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [1:0]   valid_i;
  logic [127:0] entry_i;
  logic         flush_i;
  logic         valid_o;
  logic [63:0]  entry_o;
  logic         ready_i;
  logic [4:0]   count_o;
  logic         overflow_o;
  logic [15:0]  drop_cnt_o;

  te_commit_fifo #(.NRET(2), .ENTRY_W(64), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (valid_i),
    .entry_i    (entry_i),
    .flush_i    (flush_i),
    .valid_o    (valid_o),
    .entry_o    (entry_o),
    .ready_i    (ready_i),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q [$];
  int          exp_drops = 0;
  logic        exp_ovf = 1'b0;
  int          model_wr = 0;

  // Drives one cycle, samples the head before the edge, then updates the model.
  task automatic drive(input logic [1:0] v, input logic [63:0] a, input logic [63:0] b,
                       input logic rdy, input logic fl,
                       output logic did_pop, output logic [63:0] seen, output logic [63:0] want);
    logic [63:0] lane [2];
    int          drops;
    valid_i = v;
    entry_i = {b, a};
    ready_i = rdy;
    flush_i = fl;
    lane[0] = a;
    lane[1] = b;
    drops   = 0;
    seen    = entry_o;
    did_pop = rdy && !fl && (exp_q.size() != 0);
    want    = did_pop ? exp_q[0] : 64'd0;
    @(posedge clk_i);
    #1;
    if (fl) begin
      exp_q.delete();
      exp_ovf  = 1'b0;
      model_wr = 0;
    end else begin
      if (did_pop) void'(exp_q.pop_front());
      for (int k = 0; k < 2; k++) begin
        if (v[k]) begin
          if (exp_q.size() < DEPTH) begin
            exp_q.push_back(lane[k]);
            model_wr = (model_wr + 1) % DEPTH;
          end else begin
            drops++;
          end
        end
      end
      exp_ovf   = (drops > 0);
      exp_drops = (exp_drops + drops > 65535) ? 65535 : exp_drops + drops;
    end
    valid_i = 2'b00;
    ready_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    valid_i = 2'b00;
    entry_i = '0;
    ready_i = 1'b0;
    flush_i = 1'b0;
    #12;
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    n_vec++; if (entry_o !== 64'd0) begin n_err++; $display("FAIL reset_entry got=%h want=0", entry_o); end
    n_vec++; if (count_o !== 5'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", count_o); end
    n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b want=0", overflow_o); end
    n_vec++; if (drop_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_drops got=%0d want=0", drop_cnt_o); end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_dual_push();
    logic p; logic [63:0] s, w;
    drive(2'b11, 64'hA, 64'hB, 1'b1, 1'b0, p, s, w);
    n_vec++; if (valid_o !== 1'b1 || entry_o !== 64'hA) begin n_err++; $display("FAIL dual_first got=%b/%h want=1/a", valid_o, entry_o); end
    drive(2'b00, 64'd0, 64'd0, 1'b1, 1'b0, p, s, w);
    n_vec++; if (!p || s !== w) begin n_err++; $display("FAIL dual_pop_a got=%h want=%h", s, w); end
    n_vec++; if (entry_o !== 64'hB) begin n_err++; $display("FAIL dual_second got=%h want=b", entry_o); end
    drive(2'b00, 64'd0, 64'd0, 1'b1, 1'b0, p, s, w);
    n_vec++; if (!p || s !== w) begin n_err++; $display("FAIL dual_pop_b got=%h want=%h", s, w); end
    n_vec++; if (valid_o !== 1'b0 || entry_o !== 64'd0) begin n_err++; $display("FAIL dual_empty got=%b/%h want=0/0", valid_o, entry_o); end
  endtask

  task automatic test_lane_gap();
    logic p; logic [63:0] s, w;
    drive(2'b10, 64'hDEAD, 64'hC, 1'b0, 1'b0, p, s, w);
    n_vec++; if (count_o !== 5'd1) begin n_err++; $display("FAIL gap_count got=%0d want=1", count_o); end
    n_vec++; if (entry_o !== 64'hC) begin n_err++; $display("FAIL gap_entry got=%h want=c", entry_o); end
    n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL gap_ovf got=%b want=0", overflow_o); end
    drive(2'b00, 64'd0, 64'd0, 1'b1, 1'b0, p, s, w);
    n_vec++; if (!p || s !== w || valid_o !== 1'b0) begin n_err++; $display("FAIL gap_pop got=%h/%b want=%h/0", s, valid_o, w); end
  endtask

  task automatic test_fill_overflow();
    logic p; logic [63:0] s, w;
    for (int i = 0; i < 9; i++) begin
      drive(2'b11, 64'h100 + 64'(2*i), 64'h101 + 64'(2*i), 1'b0, 1'b0, p, s, w);
      n_vec++; if (int'(count_o) !== exp_q.size() || overflow_o !== exp_ovf) begin
        n_err++; $display("FAIL fill_%0d got=%0d/%b want=%0d/%b", i, count_o, overflow_o, exp_q.size(), exp_ovf);
      end
      if (i == 7) begin
        n_vec++; if (count_o !== 5'd16 || overflow_o !== 1'b0) begin n_err++; $display("FAIL fill_full got=%0d/%b want=16/0", count_o, overflow_o); end
      end
    end
    n_vec++; if (overflow_o !== 1'b1 || drop_cnt_o !== 16'd2) begin n_err++; $display("FAIL fill_drop got=%b/%0d want=1/2", overflow_o, drop_cnt_o); end
    drive(2'b00, 64'd0, 64'd0, 1'b0, 1'b0, p, s, w);
    n_vec++; if (overflow_o !== 1'b0 || count_o !== 5'd16) begin n_err++; $display("FAIL fill_pulse got=%b/%0d want=0/16", overflow_o, count_o); end
  endtask

  task automatic test_full_pop();
    logic p; logic [63:0] s, w;
    drive(2'b11, 64'hE0, 64'hE1, 1'b1, 1'b0, p, s, w);
    n_vec++; if (!p || s !== 64'h100) begin n_err++; $display("FAIL fullpop_head got=%h want=100", s); end
    n_vec++; if (count_o !== 5'd16 || drop_cnt_o !== 16'd3 || overflow_o !== 1'b1) begin
      n_err++; $display("FAIL fullpop_state got=%0d/%0d/%b want=16/3/1", count_o, drop_cnt_o, overflow_o);
    end
    for (int i = 0; i < 16; i++) begin
      drive(2'b00, 64'd0, 64'd0, 1'b1, 1'b0, p, s, w);
      n_vec++; if (!p || s !== w) begin n_err++; $display("FAIL drain_%0d got=%h want=%h", i, s, w); end
    end
    n_vec++; if (s !== 64'hE0 || valid_o !== 1'b0) begin n_err++; $display("FAIL drain_last got=%h/%b want=e0/0", s, valid_o); end
  endtask

  task automatic test_wrap();
    logic p; logic [63:0] s, w;
    for (int i = 0; i < 32 && model_wr != DEPTH - 1; i++) begin
      drive(2'b01, 64'h200 + 64'(i), 64'd0, 1'b1, 1'b0, p, s, w);
      if (p) begin
        n_vec++; if (s !== w) begin n_err++; $display("FAIL wrap_fill_%0d got=%h want=%h", i, s, w); end
      end
    end
    drive(2'b00, 64'd0, 64'd0, 1'b1, 1'b0, p, s, w);
    n_vec++; if (model_wr !== DEPTH - 1 || valid_o !== 1'b0) begin n_err++; $display("FAIL wrap_setup got=%0d/%b want=15/0", model_wr, valid_o); end
    drive(2'b11, 64'h9, 64'hF, 1'b0, 1'b0, p, s, w);
    n_vec++; if (count_o !== 5'd2 || entry_o !== 64'h9) begin n_err++; $display("FAIL wrap_p got=%0d/%h want=2/9", count_o, entry_o); end
    drive(2'b00, 64'd0, 64'd0, 1'b1, 1'b0, p, s, w);
    n_vec++; if (entry_o !== 64'hF) begin n_err++; $display("FAIL wrap_q got=%h want=f", entry_o); end
    drive(2'b00, 64'd0, 64'd0, 1'b1, 1'b0, p, s, w);
    n_vec++; if (!p || s !== 64'hF || valid_o !== 1'b0) begin n_err++; $display("FAIL wrap_end got=%h/%b want=f/0", s, valid_o); end
  endtask

  task automatic test_flush_reset();
    logic p; logic [63:0] s, w;
    drive(2'b11, 64'h31, 64'h32, 1'b0, 1'b0, p, s, w);
    drive(2'b11, 64'h33, 64'h34, 1'b0, 1'b0, p, s, w);
    drive(2'b01, 64'h35, 64'h0,  1'b0, 1'b0, p, s, w);
    n_vec++; if (count_o !== 5'd5) begin n_err++; $display("FAIL flush_pre got=%0d want=5", count_o); end
    drive(2'b11, 64'h36, 64'h37, 1'b1, 1'b1, p, s, w);
    n_vec++; if (count_o !== 5'd0 || valid_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_err++; $display("FAIL flush_state got=%0d/%b/%b want=0/0/0", count_o, valid_o, overflow_o);
    end
    n_vec++; if (drop_cnt_o !== 16'd3 || entry_o !== 64'd0) begin n_err++; $display("FAIL flush_keep got=%0d/%h want=3/0", drop_cnt_o, entry_o); end
    for (int i = 0; i < 9; i++) drive(2'b11, 64'h400 + 64'(i), 64'h500 + 64'(i), 1'b0, 1'b0, p, s, w);
    n_vec++; if (overflow_o !== 1'b1 || drop_cnt_o !== 16'(exp_drops)) begin
      n_err++; $display("FAIL burst_drop got=%b/%0d want=1/%0d", overflow_o, drop_cnt_o, exp_drops);
    end
    valid_i = 2'b11;
    ready_i = 1'b1;
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    n_vec++; if (valid_o !== 1'b0 || entry_o !== 64'd0 || count_o !== 5'd0) begin
      n_err++; $display("FAIL async_rst got=%b/%h/%0d want=0/0/0", valid_o, entry_o, count_o);
    end
    n_vec++; if (overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) begin n_err++; $display("FAIL async_rst_rep got=%b/%0d want=0/0", overflow_o, drop_cnt_o); end
    exp_q.delete();
    exp_drops = 0;
    exp_ovf   = 1'b0;
    model_wr  = 0;
    valid_i   = 2'b00;
    ready_i   = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    n_vec++; if (valid_o !== 1'b0 || count_o !== 5'd0) begin n_err++; $display("FAIL post_rst got=%b/%0d want=0/0", valid_o, count_o); end
  endtask

  initial begin
    test_reset();
    test_dual_push();
    test_lane_gap();
    test_fill_overflow();
    test_full_pop();
    test_wrap();
    test_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
